// File: rtl/z16_alu_mc_if.sv
// Request/result handshake bundle for the z16_alu_mc multi-cycle ALU.
// The master drives requests and result acceptance. The slave is the ALU.
interface z16_alu_mc_if #(
    parameter int WIDTH = 16
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_data_a;
    logic [WIDTH-1:0] i_data_b;
    logic [3:0]       i_ctrl;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_data;
    logic [WIDTH-1:0] o_data_hi;
    logic [3:0]       o_flags;
    logic             o_err;

    modport master (
        output i_valid, i_data_a, i_data_b, i_ctrl, i_ready,
        input  o_ready, o_valid, o_data, o_data_hi, o_flags, o_err
    );

    modport slave (
        input  i_valid, i_data_a, i_data_b, i_ctrl, i_ready,
        output o_ready, o_valid, o_data, o_data_hi, o_flags, o_err
    );
endinterface

// File: rtl/z16_alu_mc.sv
// Multi-cycle ALU. Most ops finish in a single cycle. MUL uses shift-add and DIV uses
// restoring division, and each of these takes WIDTH iterations.
module z16_alu_mc #(
    parameter int WIDTH = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    z16_alu_mc_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3, OP_OR = 4'd4,
        OP_AND = 4'd5, OP_XOR = 4'd6, OP_SHL = 4'd7, OP_SHR = 4'd8, OP_SRA = 4'd9
    } op_t;

    state_t           state_q, state_d;
    logic             live_q, live_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d, res_hi_q, res_hi_d;
    logic [3:0]       flags_q, flags_d;
    logic             err_q, err_d;

    logic             ready, valid, accept;
    logic [WIDTH:0]   add_full, sub_full;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c, sc_v, sc_err;
    logic [WIDTH:0]   mul_sum, div_sh, div_diff;
    logic [WIDTH-1:0] step_hi, step_lo, fin_lo, fin_hi;
    logic             fin_err;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = (bus.i_ctrl == OP_MUL || bus.i_ctrl == OP_DIV) ? S_BUSY : S_DONE;
            S_BUSY: if (cnt_q == LAST) state_d = S_DONE;
            S_DONE: if (bus.i_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // live_q keeps o_ready low until the first clock edge after reset release.
    always_comb begin
        ready = (state_q == S_IDLE) && live_q;
        valid = (state_q == S_DONE);
    end

    assign accept = bus.i_valid && ready;
    assign live_d = 1'b1;

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        sc_res   = '0;
        sc_c     = 1'b0;
        sc_v     = 1'b0;
        sc_err   = 1'b0;
        add_full = {1'b0, bus.i_data_a} + {1'b0, bus.i_data_b};
        sub_full = {1'b0, bus.i_data_a} - {1'b0, bus.i_data_b};
        sh       = bus.i_data_b[SHW-1:0];
        case (bus.i_ctrl)
            OP_ADD: begin
                sc_res = add_full[WIDTH-1:0];
                sc_c   = add_full[WIDTH];
                sc_v   = (bus.i_data_a[WIDTH-1] == bus.i_data_b[WIDTH-1]) &&
                         (sc_res[WIDTH-1] != bus.i_data_a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = sub_full[WIDTH-1:0];
                sc_c   = sub_full[WIDTH];
                sc_v   = (bus.i_data_a[WIDTH-1] != bus.i_data_b[WIDTH-1]) &&
                         (sc_res[WIDTH-1] != bus.i_data_a[WIDTH-1]);
            end
            OP_MUL, OP_DIV: sc_res = '0;
            OP_OR:  sc_res = bus.i_data_a | bus.i_data_b;
            OP_AND: sc_res = bus.i_data_a & bus.i_data_b;
            OP_XOR: sc_res = bus.i_data_a ^ bus.i_data_b;
            OP_SHL: sc_res = bus.i_data_a << sh;
            OP_SHR: sc_res = bus.i_data_a >> sh;
            OP_SRA: sc_res = $unsigned($signed(bus.i_data_a) >>> sh);
            default: sc_err = 1'b1;
        endcase
    end

    // hi_q/lo_q hold {partial product, multiplier} for MUL, and {remainder, quotient} for DIV.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        div_sh   = {hi_q, lo_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, b_q};
        if (op_q == OP_DIV) begin
            if (div_diff[WIDTH]) begin
                step_hi = div_sh[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b0};
            end else begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        flags_d  = flags_q;
        err_d    = err_q;
        fin_lo   = step_lo;
        fin_hi   = step_hi;
        fin_err  = 1'b0;
        case (state_q)
            S_IDLE: if (accept) begin
                a_d   = bus.i_data_a;
                b_d   = bus.i_data_b;
                op_d  = bus.i_ctrl;
                cnt_d = '0;
                hi_d  = '0;
                if (bus.i_ctrl == OP_MUL) begin
                    lo_d = bus.i_data_b;
                end else if (bus.i_ctrl == OP_DIV) begin
                    lo_d = bus.i_data_a;
                end else begin
                    res_d    = sc_res;
                    res_hi_d = '0;
                    flags_d  = {sc_res[WIDTH-1], ~|sc_res, sc_c, sc_v};
                    err_d    = sc_err;
                end
            end
            S_BUSY: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == LAST) begin
                    if (op_q == OP_DIV && b_q == '0) begin
                        fin_lo  = '1;
                        fin_hi  = a_q;
                        fin_err = 1'b1;
                    end
                    res_d    = fin_lo;
                    res_hi_d = fin_hi;
                    flags_d  = {fin_lo[WIDTH-1], ~|fin_lo, 2'b00};
                    err_d    = fin_err;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            live_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            res_hi_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            live_q   <= live_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
        end
    end

    assign bus.o_ready   = ready;
    assign bus.o_valid   = valid;
    assign bus.o_data    = res_q;
    assign bus.o_data_hi = res_hi_q;
    assign bus.o_flags   = flags_q;
    assign bus.o_err     = err_q;
endmodule

// File: tb/tb_z16_alu_mc.sv
// Testbench for z16_alu_mc at WIDTH=16. It runs directed vectors, handshake and reset
// sequences, and random operations checked against an arithmetic reference model.
module tb_z16_alu_mc;
    logic i_clk;
    logic i_rst_n;
    int   total = 0;
    int   bad   = 0;

    z16_alu_mc_if #(.WIDTH(16)) bus ();

    z16_alu_mc #(.WIDTH(16)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [15:0] hi;
        logic [3:0]  fl;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // The reference model computes each result from the opcode definitions with plain integer arithmetic.
    function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic [15:0] rh,
                                  output logic [3:0] fl, output logic e, output int lat);
        int unsigned ua, ub, s, p;
        int          sa, sb, ss;
        logic        c, v;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        c = 1'b0; v = 1'b0; e = 1'b0; rh = '0; lat = 1; r = '0;
        case (op)
            4'd0: begin s = ua + ub; r = s[15:0]; c = (s > 65535); ss = sa + sb; v = (ss > 32767) || (ss < -32768); end
            4'd1: begin s = ua - ub; r = s[15:0]; c = (ua < ub); ss = sa - sb; v = (ss > 32767) || (ss < -32768); end
            4'd2: begin p = ua * ub; r = p[15:0]; rh = p[31:16]; lat = 17; end
            4'd3: begin
                lat = 17;
                if (ub == 0) begin r = 16'hFFFF; rh = a; e = 1'b1; end
                else begin s = ua / ub; r = s[15:0]; s = ua % ub; rh = s[15:0]; end
            end
            4'd4: r = a | b;
            4'd5: r = a & b;
            4'd6: r = a ^ b;
            4'd7: r = a << b[3:0];
            4'd8: r = a >> b[3:0];
            4'd9: r = $signed(a) >>> b[3:0];
            default: e = 1'b1;
        endcase
        fl = {r[15], (r == 16'h0), c, v};
    endfunction

    // Issue one request with i_ready held high and capture the result and its latency.
    task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output logic [15:0] rh, output logic [3:0] fl,
                         output logic e, output int lat, output int rdy_busy);
        int guard;
        guard = 0;
        while (!bus.o_ready && guard < 50) begin
            @(negedge i_clk);
            guard++;
        end
        check("ready_before_accept", {31'b0, bus.o_ready}, 32'd1);
        bus.i_valid  = 1'b1;
        bus.i_ctrl   = op;
        bus.i_data_a = a;
        bus.i_data_b = b;
        bus.i_ready  = 1'b1;
        @(posedge i_clk);
        #1;
        bus.i_valid  = 1'b0;
        bus.i_data_a = 16'($urandom);
        bus.i_data_b = 16'($urandom);
        bus.i_ctrl   = 4'($urandom);
        lat = 0;
        rdy_busy = 0;
        do begin
            @(negedge i_clk);
            lat++;
            if (bus.o_ready) rdy_busy++;
        end while (!bus.o_valid && lat < 40);
        r  = bus.o_data;
        rh = bus.o_data_hi;
        fl = bus.o_flags;
        e  = bus.o_err;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r, rh, er, erh, held;
        logic [3:0]  fl, efl, op;
        logic        e, ee;
        int          lat, elat, rb, stale;

        vecs[0]  = '{4'd0,  16'h0004, 16'h0008, 16'h000C, 16'h0000, 4'b0000, 1'b0, 1};
        vecs[1]  = '{4'd1,  16'h0004, 16'h0008, 16'hFFFC, 16'h0000, 4'b1010, 1'b0, 1};
        vecs[2]  = '{4'd0,  16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 4'b1001, 1'b0, 1};
        vecs[3]  = '{4'd2,  16'h0100, 16'h0300, 16'h0000, 16'h0003, 4'b0100, 1'b0, 17};
        vecs[4]  = '{4'd3,  16'd100,  16'd7,    16'h000E, 16'h0002, 4'b0000, 1'b0, 17};
        vecs[5]  = '{4'd3,  16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 4'b1000, 1'b1, 17};
        vecs[6]  = '{4'd0,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b0110, 1'b0, 1};
        vecs[7]  = '{4'd1,  16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 4'b0001, 1'b0, 1};
        vecs[8]  = '{4'd2,  16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b0000, 1'b0, 17};
        vecs[9]  = '{4'd7,  16'h0001, 16'h0013, 16'h0008, 16'h0000, 4'b0000, 1'b0, 1};
        vecs[10] = '{4'd8,  16'h8000, 16'h0000, 16'h8000, 16'h0000, 4'b1000, 1'b0, 1};
        vecs[11] = '{4'd9,  16'h8000, 16'h0004, 16'hF800, 16'h0000, 4'b1000, 1'b0, 1};
        vecs[12] = '{4'd6,  16'hF0F0, 16'hFF00, 16'h0FF0, 16'h0000, 4'b0000, 1'b0, 1};
        vecs[13] = '{4'd12, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 4'b0100, 1'b1, 1};
        vecs[14] = '{4'd5,  16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0000, 4'b0000, 1'b0, 1};
        vecs[15] = '{4'd4,  16'h00F0, 16'h0F00, 16'h0FF0, 16'h0000, 4'b0000, 1'b0, 1};
        vecs[16] = '{4'd1,  16'h0005, 16'h0005, 16'h0000, 16'h0000, 4'b0100, 1'b0, 1};
        vecs[17] = '{4'd3,  16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 4'b1000, 1'b0, 17};
        vecs[18] = '{4'd8,  16'hF000, 16'h001C, 16'h000F, 16'h0000, 4'b0000, 1'b0, 1};

        i_rst_n = 1'b0;
        bus.i_valid = 1'b0; bus.i_ready = 1'b0; bus.i_ctrl = '0;
        bus.i_data_a = '0; bus.i_data_b = '0;
        #1;
        check("rst_ready", {31'b0, bus.o_ready}, 32'd0);
        check("rst_valid", {31'b0, bus.o_valid}, 32'd0);
        check("rst_data",  {16'b0, bus.o_data}, 32'd0);
        check("rst_flags", {28'b0, bus.o_flags}, 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        check("ready_before_first_edge", {31'b0, bus.o_ready}, 32'd0);
        @(posedge i_clk);
        #1;
        check("ready_after_release", {31'b0, bus.o_ready}, 32'd1);

        for (int i = 0; i < 19; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, rh, fl, e, lat, rb);
            check($sformatf("v%0d_lat", i),   lat, vecs[i].lat);
            check($sformatf("v%0d_data", i),  {16'b0, r}, {16'b0, vecs[i].res});
            check($sformatf("v%0d_hi", i),    {16'b0, rh}, {16'b0, vecs[i].hi});
            check($sformatf("v%0d_flags", i), {28'b0, fl}, {28'b0, vecs[i].fl});
            check($sformatf("v%0d_err", i),   {31'b0, e}, {31'b0, vecs[i].err});
            check($sformatf("v%0d_ready_busy", i), rb, 0);
        end

        // SRA is held under backpressure while a stray request is pending.
        while (!bus.o_ready) @(negedge i_clk);
        bus.i_valid = 1'b1; bus.i_ctrl = 4'd9; bus.i_data_a = 16'h8000; bus.i_data_b = 16'h0004;
        bus.i_ready = 1'b0;
        @(posedge i_clk);
        #1;
        bus.i_ctrl = 4'd0; bus.i_data_a = 16'h1111; bus.i_data_b = 16'h2222;
        @(negedge i_clk);
        check("bp_valid0", {31'b0, bus.o_valid}, 32'd1);
        check("bp_data0",  {16'b0, bus.o_data}, 32'h0000F800);
        held = bus.o_data;
        for (int k = 0; k < 5; k++) begin
            @(negedge i_clk);
            check($sformatf("bp_valid%0d", k + 1), {31'b0, bus.o_valid}, 32'd1);
            check($sformatf("bp_data%0d", k + 1),  {16'b0, bus.o_data}, {16'b0, held});
            check($sformatf("bp_flags%0d", k + 1), {28'b0, bus.o_flags}, 32'b1000);
            check($sformatf("bp_ready%0d", k + 1), {31'b0, bus.o_ready}, 32'd0);
        end
        bus.i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        check("bp_ready_after", {31'b0, bus.o_ready}, 32'd1);
        check("bp_valid_after", {31'b0, bus.o_valid}, 32'd0);
        bus.i_valid = 1'b0;

        // Reset is asserted while a MUL is in BUSY.
        @(negedge i_clk);
        bus.i_valid = 1'b1; bus.i_ctrl = 4'd2; bus.i_data_a = 16'h1234; bus.i_data_b = 16'h5678;
        @(posedge i_clk);
        #1;
        bus.i_valid = 1'b0;
        repeat (8) @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check("mr_valid", {31'b0, bus.o_valid}, 32'd0);
        check("mr_ready", {31'b0, bus.o_ready}, 32'd0);
        check("mr_data",  {16'b0, bus.o_data}, 32'd0);
        check("mr_hi",    {16'b0, bus.o_data_hi}, 32'd0);
        check("mr_flags", {28'b0, bus.o_flags}, 32'd0);
        check("mr_err",   {31'b0, bus.o_err}, 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        stale = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge i_clk);
            if (bus.o_valid) stale++;
        end
        check("mr_no_stale_valid", stale, 0);
        do_op(4'd0, 16'h1111, 16'h2222, r, rh, fl, e, lat, rb);
        check("mr_add_lat",  lat, 1);
        check("mr_add_data", {16'b0, r}, 32'h00003333);
        check("mr_add_flags", {28'b0, fl}, 32'd0);

        for (int n = 0; n < 150; n++) begin
            op = (n % 4 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
            r  = 16'($urandom);
            rh = (n % 7 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            model(op, r, rh, er, erh, efl, ee, elat);
            do_op(op, r, rh, r, rh, fl, e, lat, rb);
            check($sformatf("rnd%0d_op%0d_lat", n, op),   lat, elat);
            check($sformatf("rnd%0d_op%0d_data", n, op),  {16'b0, r}, {16'b0, er});
            check($sformatf("rnd%0d_op%0d_hi", n, op),    {16'b0, rh}, {16'b0, erh});
            check($sformatf("rnd%0d_op%0d_flags", n, op), {28'b0, fl}, {28'b0, efl});
            check($sformatf("rnd%0d_op%0d_err", n, op),   {31'b0, e}, {31'b0, ee});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
